// File: rtl/sseg_pkg.sv
// Shared seven-segment definitions: digit count, blanking codes and the digit-index type.
// Also used by the rotating-banner block that feeds the scan driver.
package sseg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'hF;

  typedef logic [$clog2(NUM_DIGITS)-1:0] digit_t;
  typedef logic [7:0] seg_t;
  typedef logic [NUM_DIGITS-1:0] an_t;

  // One-cold anode enable for the selected digit.
  function automatic an_t anode_select(input digit_t dig);
    return ~(an_t'(1) << dig);
  endfunction

endpackage

// File: rtl/sseg_scan_timer.sv
// Slot counter and digit index for the multiplexed display, plus the frame-start pulse.
// Holding en low parks the scan at digit 0, slot cycle 0.
module sseg_scan_timer
  import sseg_pkg::*;
#(
  parameter int DIG_CYC = 100000,
  parameter int CNT_W = (DIG_CYC > 1) ? $clog2(DIG_CYC) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output digit_t           dig,
  output logic             at_start,
  output logic             frame_tick
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIG_CYC - 1);
  localparam digit_t DIG_LAST = digit_t'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt_q;
  digit_t           dig_q;
  logic             tick_q;

  assign at_start = (cnt_q == '0) && (dig_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      dig_q <= '0;
    end else if (!en) begin
      cnt_q <= '0;
      dig_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
      dig_q <= (dig_q == DIG_LAST) ? digit_t'(0) : dig_q + 1'b1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= en && at_start;
    end
  end

  assign cnt        = cnt_q;
  assign dig        = dig_q;
  assign frame_tick = tick_q;

endmodule

// File: rtl/sseg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with per-slot blanking and PWM brightness.
// Patterns and brightness are captured once per frame so a frame is always drawn consistently.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int DIG_CYC   = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_en,
  input  logic [NUM_DIGITS-1:0][7:0] i_map_n,
  input  logic [2:0]                 i_bright,
  output logic [NUM_DIGITS-1:0]      o_an_n,
  output logic [7:0]                 o_sseg_n,
  output logic                       o_frame_tick
);

  localparam int ON_CYC = DIG_CYC - BLANK_CYC;
  localparam int CNT_W  = (DIG_CYC > 1) ? $clog2(DIG_CYC) : 1;
  // Four spare bits keep (bright+1)*ON_CYC/8 and the offset subtraction overflow-free.
  localparam int LEN_W  = CNT_W + 4;
  localparam logic [LEN_W-1:0] BLANK_W = LEN_W'(BLANK_CYC);
  localparam logic [LEN_W-1:0] ON_STEP = LEN_W'(ON_CYC / 8);

  generate
    if (BLANK_CYC < 1) begin : g_bad_blank_low
      $error("sseg_scan_driver: BLANK_CYC must be at least 1");
    end
    if (BLANK_CYC >= DIG_CYC) begin : g_bad_blank_high
      $error("sseg_scan_driver: BLANK_CYC must be smaller than DIG_CYC");
    end
    if ((ON_CYC % 8) != 0) begin : g_bad_on_cyc
      $error("sseg_scan_driver: DIG_CYC-BLANK_CYC must be a multiple of 8");
    end
  endgenerate

  logic [CNT_W-1:0]             cnt;
  digit_t                       dig;
  logic                         at_start;
  logic                         frame_tick;
  logic [NUM_DIGITS-1:0][7:0]   snap_q;
  logic [2:0]                   bright_q;
  logic [LEN_W-1:0]             cnt_w;
  logic [LEN_W-1:0]             on_len;
  logic                         lit;
  an_t                          an_q;
  seg_t                         sseg_q;

  sseg_scan_timer #(
    .DIG_CYC (DIG_CYC),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .en         (i_en),
    .cnt        (cnt),
    .dig        (dig),
    .at_start   (at_start),
    .frame_tick (frame_tick)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      snap_q   <= {NUM_DIGITS{SEG_OFF}};
      bright_q <= '0;
    end else if (at_start) begin
      snap_q   <= i_map_n;
      bright_q <= i_bright;
    end
  end

  // Lit window opens after the blanking gap and lasts (bright+1)/8 of the remaining slot.
  always_comb begin
    cnt_w  = {4'b0000, cnt};
    on_len = ({{(LEN_W-3){1'b0}}, bright_q} + LEN_W'(1)) * ON_STEP;
    lit    = i_en && (cnt_w >= BLANK_W) && ((cnt_w - BLANK_W) < on_len);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      an_q   <= AN_OFF;
      sseg_q <= SEG_OFF;
    end else begin
      an_q   <= lit ? anode_select(dig) : AN_OFF;
      sseg_q <= lit ? snap_q[dig] : SEG_OFF;
    end
  end

  assign o_an_n       = an_q;
  assign o_sseg_n     = sseg_q;
  assign o_frame_tick = frame_tick;

endmodule

// File: doc/sseg_scan_driver.md
SSEG_SCAN_DRIVER -- requirements
Module: sseg_scan_driver

Interface
REQ-001 The block SHALL have parameter DIG_CYC, default 100000, giving i_clk cycles per digit slot (1 ms at 100 MHz).
REQ-002 The block SHALL have parameter BLANK_CYC, default 1000, giving dead-time cycles at the start of each slot (anode off, segments off).
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single system clock; all state on its rising edge.
REQ-004 The block SHALL have port i_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port i_en, input, 1 bit: 1 = scan active, 0 = display dark and scan held.
REQ-006 The block SHALL have port i_map_n, input, 4 x 8 bits (element k = digit k, 0 = rightmost): active-low segment patterns {dp,g..a} from the rotating banner.
REQ-007 The block SHALL have port i_bright, input, 3 bits: brightness level 0 (dimmest) to 7 (full).
REQ-008 The block SHALL have port o_an_n, output, 4 bits: active-low anode enables, at most one low at a time.
REQ-009 The block SHALL have port o_sseg_n, output, 8 bits: active-low segment drive.
REQ-010 The block SHALL have port o_frame_tick, output, 1 bit: one-cycle pulse at the start of each frame.

Function
REQ-011 The block SHALL keep a slot counter cnt (0..DIG_CYC-1) and a digit index dig (0..3); while i_en=1, cnt increments each cycle, and at DIG_CYC-1 it wraps to 0 and dig advances 0->1->2->3->0.
REQ-012 While i_en=0, cnt and dig SHALL be forced to 0 synchronously; the first cycle with i_en=1 starts frame slot (0,0).
REQ-013 On every edge where (dig,cnt)=(0,0), the block SHALL load all four i_map_n elements into a frame snapshot and i_bright into a brightness register; no mid-frame input change SHALL affect the current frame.
REQ-014 ON_CYC = DIG_CYC-BLANK_CYC; the block SHALL define lit = i_en AND cnt>=BLANK_CYC AND (cnt-BLANK_CYC) < (bright+1)*ON_CYC/8, computed with widths that cannot overflow.
REQ-015 Outputs SHALL be registered, one cycle after the (dig,cnt) state: o_an_n <= lit ? ~(1<<dig) : 4'hF.
REQ-016 o_sseg_n SHALL be registered as lit ? snapshot[dig] : 8'hFF, so segments are never driven while all anodes are off.
REQ-017 o_frame_tick SHALL be registered high for exactly one cycle following each cycle with i_en=1 and (dig,cnt)=(0,0), and SHALL not pulse while i_en=0.
REQ-018 At bright=7 the anode SHALL be lit for all ON_CYC cycles of each slot; at bright=0 it SHALL be lit for ON_CYC/8 cycles.
REQ-019 Elaboration SHALL fail if BLANK_CYC<1, BLANK_CYC>=DIG_CYC, or ON_CYC is not a multiple of 8.

Reset
REQ-020 Asserting i_rst_n=0 SHALL immediately force cnt=0, dig=0, o_an_n=4'hF, o_sseg_n=8'hFF, o_frame_tick=0, snapshot all 8'hFF and brightness 0, including mid-slot.
REQ-021 After release, the first active clock SHALL begin a frame at (0,0) exactly as after i_en rising.

Structure
REQ-022 Shared package sseg_pkg SHALL hold NUM_DIGITS=4, SEG_OFF=8'hFF, AN_OFF=4'hF, and the digit-index typedef, also used by the banner block.
REQ-023 The cnt/dig timing and o_frame_tick generation SHALL live in sub-module sseg_scan_timer; the top holds the snapshot, brightness compare and output registers.

Verification (DIG_CYC=24, BLANK_CYC=8, ON_CYC=16)
REQ-024 Reset, i_en=1, i_bright=7, i_map_n={8'hC0,8'hF9,8'hA4,8'hB0} -> o_frame_tick pulses every 96 cycles; per slot 8 dark cycles then 16 cycles of o_an_n=4'hE/D/B/7 with the matching pattern.
REQ-025 i_bright=0 -> each slot lit exactly 2 cycles; i_bright=3 -> exactly 8 cycles; o_sseg_n=8'hFF whenever o_an_n=4'hF.
REQ-026 Change i_map_n[2] and i_bright mid-frame -> current frame unchanged; new values appear from the next o_frame_tick.
REQ-027 Drop i_en during digit 2 -> next cycle o_an_n=4'hF, o_sseg_n=8'hFF, no ticks; re-raise -> tick and digit 0 slot restart.
REQ-028 Assert i_rst_n low mid-slot asynchronously -> outputs go to 4'hF/8'hFF/0 before the next clock edge; scan resumes at digit 0.
